// File: rtl/sw_pkg.sv
// Shared constants and helpers for the switch conditioning path that feeds
// the 8-to-3 priority encoder and the seven-segment display.
package sw_pkg;

    localparam int DEB_STABLE_DEFAULT = 16;
    localparam int DEB_SYNC_DEFAULT   = 2;

    // Width of a counter that must reach STABLE_CYCLES-1 without wrapping.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: synchroniser chain, stability counter and the
// debounced level. A level is accepted only after STABLE_CYCLES mismatches.
module debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int SYNC_STAGES   = DEB_SYNC_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_next
);

    localparam int              CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_s;
    logic                   w_accept;

    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_accept     = (w_s != r_level) && (r_cnt == LAST);
    assign o_level_next = w_accept ? w_s : r_level;
    assign o_level      = r_level;

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce8.sv
// Debounces WIDTH code switches plus the enable switch and flags every
// change of the debounced word with a one-cycle registered pulse.
module switch_debounce8
    import sw_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int SYNC_STAGES   = DEB_SYNC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_en_sw,
    output logic [WIDTH-1:0] o_code,
    output logic             o_en,
    output logic             o_change
);

    logic [WIDTH:0] w_raw;
    logic [WIDTH:0] w_word;
    logic [WIDTH:0] w_next_word;
    logic           r_change;

    assign w_raw = {i_en_sw, i_sw};

    for (genvar g = 0; g <= WIDTH; g++) begin : g_chan
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_bit (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_raw       (w_raw[g]),
            .o_level     (w_word[g]),
            .o_level_next(w_next_word[g])
        );
    end

    // Comparing next word with the current one lets the pulse land in the
    // same cycle the new word appears, while still coming from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_change <= 1'b0;
        end else begin
            r_change <= (w_next_word != w_word);
        end
    end

    assign o_code   = w_word[WIDTH-1:0];
    assign o_en     = w_word[WIDTH];
    assign o_change = r_change;

endmodule

// File: tb/tb_switch_debounce8.sv
// Randomised and directed bench for switch_debounce8 with a queue-based
// scoreboard fed by a behavioural model of the debounce rules.
module tb_switch_debounce8;

    localparam int W  = 8;
    localparam int ST = 16;
    localparam int SY = 2;
    localparam int LAT = ST + SY;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic         en_sw;
    logic [W-1:0] o_code;
    logic         o_en;
    logic         o_change;

    always #5 clk = ~clk;

    switch_debounce8 #(.WIDTH(W), .STABLE_CYCLES(ST), .SYNC_STAGES(SY)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sw    (sw),
        .i_en_sw (en_sw),
        .o_code  (o_code),
        .o_en    (o_en),
        .o_change(o_change)
    );

    typedef struct packed {
        logic [W:0] word;
        logic       change;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel's synchronised view is the raw sample
    // taken SY edges earlier; a level is accepted after ST mismatching edges.
    logic [W:0] m_hist[$];
    logic [W:0] m_d;
    int         m_run[W+1];
    logic       m_chg;

    task automatic model_step(input logic [W:0] raw, input logic r);
        logic [W:0] s;
        logic [W:0] old;
        if (r) begin
            m_hist.delete();
            repeat (SY) m_hist.push_back('0);
            m_d   = '0;
            m_chg = 1'b0;
            for (int c = 0; c <= W; c++) m_run[c] = 0;
        end else begin
            s   = m_hist.pop_front();
            m_hist.push_back(raw);
            old = m_d;
            for (int c = 0; c <= W; c++) begin
                if (s[c] != m_d[c]) begin
                    m_run[c]++;
                    if (m_run[c] == ST) begin
                        m_d[c]   = s[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_chg = (m_d != old);
        end
    endtask

    // One clock: drive, let the edge happen, push the model's post-edge view.
    task automatic apply(input logic [W-1:0] s_v, input logic e_v, input logic r_v);
        sw    = s_v;
        en_sw = e_v;
        rst   = r_v;
        @(posedge clk);
        model_step({e_v, s_v}, r_v);
        q_exp.push_back('{word: m_d, change: m_chg});
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check("o_code",   32'(o_code),   32'(e.word[W-1:0]));
            check("o_en",     32'(o_en),     32'(e.word[W]));
            check("o_change", 32'(o_change), 32'(e.change));
            if (o_change === 1'b1) n_pulses++;
        end
    end

    // Edges until the outputs show the driven word, bounded by 60.
    task automatic measure(input logic [W-1:0] s_v, input logic e_v, output int lat);
        lat = 0;
        while (lat < 60) begin
            apply(s_v, e_v, 1'b0);
            lat++;
            if ({o_en, o_code} == {e_v, s_v}) break;
        end
    endtask

    task automatic settle(input logic [W-1:0] s_v, input logic e_v, input int n);
        repeat (n) apply(s_v, e_v, 1'b0);
    endtask

    initial begin
        int lat;
        int p0;
        bit seen_hi;
        logic [W:0] cur;
        int hold[W+1];

        // Reset with all switches high, then release.
        repeat (5) apply(8'hFF, 1'b1, 1'b1);
        p0 = n_pulses;
        measure(8'hFF, 1'b1, lat);
        check("reset_release_latency", 32'(lat), 32'(LAT));
        settle(8'hFF, 1'b1, 3);
        check("reset_release_pulses", 32'(n_pulses - p0), 32'd1);

        // Clean step from settled zero.
        settle(8'h00, 1'b0, 25);
        p0 = n_pulses;
        measure(8'h10, 1'b0, lat);
        check("clean_step_latency", 32'(lat), 32'(LAT));
        settle(8'h10, 1'b0, 3);
        check("clean_step_pulses", 32'(n_pulses - p0), 32'd1);

        // Bounce on bit 3 every 3 cycles, ending low, then hold high.
        p0 = n_pulses;
        for (int i = 0; i < 40; i++) apply({4'h1, ((i / 3) % 2 == 0), 3'b000}, 1'b0, 1'b0);
        measure(8'h18, 1'b0, lat);
        check("bounce_latency", 32'(lat), 32'(LAT));
        settle(8'h18, 1'b0, 3);
        check("bounce_pulses", 32'(n_pulses - p0), 32'd1);

        // Glitch one edge short of acceptance is rejected.
        p0 = n_pulses;
        settle(8'h19, 1'b0, ST - 1);
        settle(8'h18, 1'b0, 40);
        check("glitch_short_pulses", 32'(n_pulses - p0), 32'd0);

        // Glitch exactly long enough is accepted, then released.
        p0 = n_pulses;
        settle(8'h19, 1'b0, ST);
        seen_hi = 1'b0;
        lat = 0;
        while (lat < 60) begin
            apply(8'h18, 1'b0, 1'b0);
            lat++;
            if (o_code[0]) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        check("glitch_min_seen_high", 32'(seen_hi), 32'd1);
        check("glitch_min_fall_latency", 32'(lat), 32'(LAT));
        settle(8'h18, 1'b0, 3);
        check("glitch_min_pulses", 32'(n_pulses - p0), 32'd2);

        // Simultaneous change of three channels.
        settle(8'h00, 1'b0, 25);
        p0 = n_pulses;
        measure(8'h81, 1'b1, lat);
        check("simultaneous_latency", 32'(lat), 32'(LAT));
        settle(8'h81, 1'b1, 3);
        check("simultaneous_pulses", 32'(n_pulses - p0), 32'd1);

        // Reset in the middle of a count discards it.
        settle(8'h00, 1'b0, 25);
        settle(8'h20, 1'b0, 10);
        check("midcount_still_low", 32'(o_code[5]), 32'd0);
        apply(8'h20, 1'b0, 1'b1);
        p0 = n_pulses;
        measure(8'h20, 1'b0, lat);
        check("midcount_latency", 32'(lat), 32'(LAT));
        settle(8'h20, 1'b0, 3);
        check("midcount_pulses", 32'(n_pulses - p0), 32'd1);

        // Random per-channel hold lengths with occasional reset.
        cur = {1'b0, 8'h20};
        for (int c = 0; c <= W; c++) hold[c] = $urandom_range(1, 30);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c <= W; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    cur[c]  = ~cur[c];
                    hold[c] = $urandom_range(1, 30);
                end
            end
            apply(cur[W-1:0], cur[W], ($urandom_range(0, 399) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
